dataflow_ctrl_sync: RTL

//  Top-level ap_ctrl_chain sequencer for an N-process HLS dataflow region (e.g. Block_proc -> normalize).
//  - Fans one ap_start out to every process and merges their ap_ready/ap_done back into one group handshake.
//  - Bounds the number of in-flight iterations.
//  - Runs a progress watchdog that latches a stall flag plus a per-process blame mask for the deadlock debug path.

---
 rtl/dataflow_ctrl_sync.sv | 128 ++++++++++++
 1 files changed

// File: rtl/dataflow_ctrl_sync.sv
// ap_ctrl_chain sequencer for an N-process dataflow region: start fan-out, ready/done merge,
// in-flight bound and a progress watchdog with a per-process blame mask.
module dataflow_ctrl_sync #(
    parameter int N_PROC       = 2,
    parameter int MAX_INFLIGHT = 2,
    parameter int WDOG_W       = 16,
    localparam int IW          = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ap_start,
    output logic              ap_ready,
    output logic              ap_done,
    input  logic              ap_continue,
    output logic              ap_idle,
    output logic [N_PROC-1:0] proc_start,
    input  logic [N_PROC-1:0] proc_ready,
    input  logic [N_PROC-1:0] proc_done,
    input  logic [N_PROC-1:0] proc_idle,
    output logic [N_PROC-1:0] proc_continue,
    output logic [IW-1:0]     inflight,
    input  logic [WDOG_W-1:0] wdog_limit,
    input  logic              stall_clr,
    output logic              stall,
    output logic [N_PROC-1:0] stall_mask
);

    typedef enum logic [0:0] {COLLECT, DONE_HOLD} state_t;

    state_t              state, state_n;
    logic [N_PROC-1:0]   ready_seen;
    logic [N_PROC-1:0]   done_seen, done_seen_n;
    logic [N_PROC-1:0]   acc;
    logic                gate;
    logic                retire;
    logic                progress;
    logic                expire;
    logic [WDOG_W-1:0]   wdog_cnt;

    // A process that already accepted this iteration is masked until the whole group accepts.
    always_comb begin
        gate       = ap_start && (inflight < IW'(MAX_INFLIGHT));
        proc_start = {N_PROC{gate}} & ~ready_seen;
        acc        = proc_start & proc_ready;
        ap_ready   = gate && (&(ready_seen | acc));
    end

    always_comb begin
        state_n       = state;
        done_seen_n   = done_seen;
        ap_done       = 1'b0;
        proc_continue = '0;
        retire        = 1'b0;
        case (state)
            COLLECT: begin
                done_seen_n = done_seen | proc_done;
                if (&done_seen_n)
                    state_n = DONE_HOLD;
            end
            DONE_HOLD: begin
                ap_done = 1'b1;
                // proc_done seen in the acknowledge cycle is the old held done; it is dropped.
                if (ap_continue) begin
                    proc_continue = '1;
                    retire        = 1'b1;
                    done_seen_n   = '0;
                    state_n       = COLLECT;
                end
            end
            default: state_n = COLLECT;
        endcase
    end

    always_comb begin
        ap_idle  = (inflight == '0) && (&proc_idle) && (state == COLLECT);
        progress = (|acc) || (|(proc_done & ~done_seen)) || retire;
        expire   = (wdog_limit != '0) && (wdog_cnt == wdog_limit) && !stall;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= COLLECT;
            done_seen  <= '0;
            ready_seen <= '0;
        end else begin
            state     <= state_n;
            done_seen <= done_seen_n;
            if (ap_ready)
                ready_seen <= '0;
            else
                ready_seen <= ready_seen | acc;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            inflight <= '0;
        end else if (ap_ready && !retire) begin
            inflight <= inflight + IW'(1);
        end else if (retire && !ap_ready && inflight != '0) begin
            inflight <= inflight - IW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wdog_cnt   <= '0;
            stall      <= 1'b0;
            stall_mask <= '0;
        end else begin
            if (stall_clr || progress || inflight == '0 || wdog_limit == '0)
                wdog_cnt <= '0;
            else if (wdog_cnt != '1)
                wdog_cnt <= wdog_cnt + WDOG_W'(1);
            if (stall_clr) begin
                stall      <= 1'b0;
                stall_mask <= '0;
            end else if (expire) begin
                stall      <= 1'b1;
                stall_mask <= ~done_seen;
            end
        end
    end

    a_no_retire_at_zero: assert property (@(posedge clock) disable iff (!reset)
        !(retire && !ap_ready && inflight == '0));

endmodule
